// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings and jump opcodes (opcodes also used by decode).
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  function automatic logic is_jump_opcode(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect controls and IF/ID outputs.
interface instruction_fetch_unit_if #(
  parameter int N  = 32,
  parameter int IM = 5
);
  logic [IM-1:0] InstructionAddress;
  logic [N-1:0]  Instruction;
  logic          Stall;
  logic          Redirect;
  logic [IM-1:0] RedirectAddress;
  logic [N-1:0]  IF_ID_Instruction;
  logic [N-1:0]  IF_ID_PCPlus1;
  logic          IF_ID_Valid;
  logic          Halted;

  modport master (
    output InstructionAddress, IF_ID_Instruction, IF_ID_PCPlus1, IF_ID_Valid, Halted,
    input  Instruction, Stall, Redirect, RedirectAddress
  );

  modport slave (
    input  InstructionAddress, IF_ID_Instruction, IF_ID_PCPlus1, IF_ID_Valid, Halted,
    output Instruction, Stall, Redirect, RedirectAddress
  );
endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// Generic pipeline register holding instruction, zero-extended PC+1 and valid; flush beats load.
module if_id_register #(
  parameter int N  = 32,
  parameter int IM = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic [N-1:0]  instruction_in,
  input  logic [IM:0]   pcplus1_in,
  output logic [N-1:0]  instruction,
  output logic [N-1:0]  pcplus1,
  output logic          valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
      pcplus1     <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= '0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instruction_in;
      pcplus1     <= {{(N-IM-1){1'b0}}, pcplus1_in};
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, BOOT/RUN/HALT FSM and next-PC mux feeding the IF/ID register.
// Define FETCH_EARLY_JUMP_EN to resolve j/jal from IF/ID with a single bubble.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int N  = 32,
  parameter int IM = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam logic [IM-1:0] PC_LAST = '1;

  fetch_state_t  state;
  logic [IM-1:0] pc;
  logic [IM:0]   pc_plus1;
  logic          halted;
  logic          early_jump;
  logic [IM-1:0] jump_target;
  logic          reg_load;
  logic          reg_flush;

  assign pc_plus1 = {1'b0, pc} + 1'b1;

`ifdef FETCH_EARLY_JUMP_EN
  assign early_jump  = (state == ST_RUN) && bus.IF_ID_Valid && !bus.Stall &&
                       is_jump_opcode(bus.IF_ID_Instruction[N-1:N-6]);
  assign jump_target = bus.IF_ID_Instruction[IM-1:0];
`else
  assign early_jump  = 1'b0;
  assign jump_target = '0;
`endif

  always_comb begin
    reg_load  = 1'b0;
    reg_flush = 1'b0;
    unique case (state)
      ST_RUN: begin
        reg_flush = bus.Redirect || early_jump;
        reg_load  = !reg_flush && !bus.Stall;
      end
      ST_HALT: reg_flush = 1'b1;
      default: ;
    endcase
  end

  // Redirect outranks early jump and stall; the last word is captured before halting, so PC never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_BOOT;
      pc     <= '0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (bus.Redirect) begin
            pc <= bus.RedirectAddress;
          end else if (early_jump) begin
            pc <= jump_target;
          end else if (!bus.Stall) begin
            if (pc == PC_LAST) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus1[IM-1:0];
            end
          end
        end
        ST_HALT: begin
          if (bus.Redirect) begin
            pc     <= bus.RedirectAddress;
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign bus.InstructionAddress = pc;
  assign bus.Halted             = halted;

  if_id_register #(
    .N  (N),
    .IM (IM)
  ) u_if_id (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (reg_load),
    .flush          (reg_flush),
    .instruction_in (bus.Instruction),
    .pcplus1_in     (pc_plus1),
    .instruction    (bus.IF_ID_Instruction),
    .pcplus1        (bus.IF_ID_PCPlus1),
    .valid          (bus.IF_ID_Valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, stall, redirect, jal, halt, async reset.
module tb_instruction_fetch_unit;

  localparam int N  = 32;
  localparam int IM = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [N-1:0] mem [0:(1<<IM)-1];

  instruction_fetch_unit_if #(.N(N), .IM(IM)) bus ();

  instruction_fetch_unit #(.N(N), .IM(IM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.Instruction = mem[bus.InstructionAddress];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pcp1,
                          input logic vld);
    chk({tag, ".instr"}, bus.IF_ID_Instruction, ins);
    chk({tag, ".pcp1"}, bus.IF_ID_PCPlus1, pcp1);
    chk({tag, ".valid"}, {31'd0, bus.IF_ID_Valid}, {31'd0, vld});
  endtask

  initial begin
    for (int i = 0; i < (1 << IM); i++) mem[i] = 32'hA000_0000 + i;
    mem[10] = 32'h0C00_03F4;  // jal, target field 0x3F4 -> low 5 bits = 20
    mem[31] = 32'h0000_0000;
    bus.Stall           = 1'b0;
    bus.Redirect        = 1'b0;
    bus.RedirectAddress = '0;

    #2;
    chk("rst.addr", {27'd0, bus.InstructionAddress}, 32'd0);
    chk_ifid("rst", 32'd0, 32'd0, 1'b0);
    chk("rst.halted", {31'd0, bus.Halted}, 32'd0);

    step();
    rst_n = 1'b1;

    // Edge 1 after release: BOOT -> RUN, nothing latched yet
    step();
    chk("boot.addr", {27'd0, bus.InstructionAddress}, 32'd0);
    chk("boot.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      step();
      chk_ifid($sformatf("seq%0d", i), 32'hA000_0000 + i, i + 1, 1'b1);
    end
    chk("seq.addr", {27'd0, bus.InstructionAddress}, 32'd4);

    // Stall three edges at PC=4
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.addr", i), {27'd0, bus.InstructionAddress}, 32'd4);
      chk_ifid($sformatf("stall%0d", i), 32'hA000_0003, 32'd4, 1'b1);
    end
    bus.Stall = 1'b0;
    step();
    chk_ifid("resume", 32'hA000_0004, 32'd5, 1'b1);

    // Redirect overrides stall
    bus.Stall = 1'b1;
    bus.Redirect = 1'b1;
    bus.RedirectAddress = 5'd9;
    step();
    bus.Stall = 1'b0;
    bus.Redirect = 1'b0;
    chk("redir.addr", {27'd0, bus.InstructionAddress}, 32'd9);
    chk_ifid("redir", 32'd0, 32'd5, 1'b0);
    step();
    chk_ifid("redir.tgt", 32'hA000_0009, 32'd10, 1'b1);

    // jal at word 10
    step();
    chk_ifid("jal", 32'h0C00_03F4, 32'd11, 1'b1);
    step();
`ifdef FETCH_EARLY_JUMP_EN
    chk("ej.addr", {27'd0, bus.InstructionAddress}, 32'd20);
    chk_ifid("ej.flush", 32'd0, 32'd11, 1'b0);
    step();
    chk_ifid("ej.tgt", 32'hA000_0014, 32'd21, 1'b1);
`else
    chk_ifid("nojump", 32'hA000_000B, 32'd12, 1'b1);
    chk("nojump.addr", {27'd0, bus.InstructionAddress}, 32'd12);
`endif

    // Redirect to 28 and run into the end-of-memory sentinel
    bus.Redirect = 1'b1;
    bus.RedirectAddress = 5'd28;
    step();
    bus.Redirect = 1'b0;
    chk("r28.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    for (int i = 28; i < 31; i++) begin
      step();
      chk_ifid($sformatf("tail%0d", i), 32'hA000_0000 + i, i + 1, 1'b1);
    end
    step();
    chk_ifid("sentinel", 32'd0, 32'd32, 1'b1);
    chk("sentinel.halted", {31'd0, bus.Halted}, 32'd1);
    chk("sentinel.addr", {27'd0, bus.InstructionAddress}, 32'd31);

    bus.Stall = 1'b1;
    step();
    chk_ifid("halt", 32'd0, 32'd32, 1'b0);
    chk("halt.halted", {31'd0, bus.Halted}, 32'd1);
    chk("halt.addr", {27'd0, bus.InstructionAddress}, 32'd31);
    bus.Stall = 1'b0;

    // Redirect to 0 leaves HALT
    bus.Redirect = 1'b1;
    bus.RedirectAddress = 5'd0;
    step();
    bus.Redirect = 1'b0;
    chk("unhalt.halted", {31'd0, bus.Halted}, 32'd0);
    chk("unhalt.addr", {27'd0, bus.InstructionAddress}, 32'd0);
    step();
    chk_ifid("unhalt.w0", 32'hA000_0000, 32'd1, 1'b1);

    // Halt again, then asynchronous reset between edges
    bus.Redirect = 1'b1;
    bus.RedirectAddress = 5'd31;
    step();
    bus.Redirect = 1'b0;
    step();
    step();
    chk("rehalt.halted", {31'd0, bus.Halted}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.addr", {27'd0, bus.InstructionAddress}, 32'd0);
    chk_ifid("areset", 32'd0, 32'd0, 1'b0);
    chk("areset.halted", {31'd0, bus.Halted}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
